// File: rtl/seq_checker_pkg.sv
// Shared state encoding and the saturating counter helper for the sequence checker.
package seq_checker_pkg;

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_TRACKING = 1'b1;

  localparam int unsigned SAT_W = 32;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned w);
    logic [SAT_W-1:0] lim;
    lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v >= lim) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/seq_checker_channel.sv
// One channel: lock/track FSM, expected-value register, failure pulse, sticky flag and counters.
module seq_checker_channel
  import seq_checker_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned START      = 1,
  parameter bit          LOCK_FIRST = 1'b0,
  parameter bit          RESYNC     = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             failure_o,
  output logic             sticky_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] beat_count_o,
  output logic [0:0]       state_o
);

  localparam logic [WIDTH-1:0] START_T  = WIDTH'(START);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [0:0]       ST_RESET = LOCK_FIRST ? ST_UNLOCKED : ST_TRACKING;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             fail_q, fail_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             mismatch;

  assign mismatch = (data_i != exp_q);

  // en_i is a pure valid with no ready: every cycle with en_i high is a consumed beat.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    fail_d   = 1'b0;
    sticky_d = sticky_q;
    err_d    = err_q;
    beat_d   = beat_q;
    if (clear_i) begin
      state_d  = ST_RESET;
      exp_d    = START_T;
      sticky_d = 1'b0;
      err_d    = '0;
      beat_d   = '0;
    end else if (en_i) begin
      beat_d = CNT_W'(sat_inc(SAT_W'(beat_q), CNT_W));
      if (state_q == ST_UNLOCKED) begin
        state_d = ST_TRACKING;
        exp_d   = data_i + ONE;
      end else begin
        fail_d = mismatch;
        exp_d  = (mismatch && RESYNC) ? data_i + ONE : exp_q + ONE;
        if (mismatch) begin
          sticky_d = 1'b1;
          err_d    = CNT_W'(sat_inc(SAT_W'(err_q), CNT_W));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RESET;
      exp_q    <= START_T;
      fail_q   <= 1'b0;
      sticky_q <= 1'b0;
      err_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      fail_q   <= fail_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
    end
  end

  assign failure_o    = fail_q;
  assign sticky_o     = sticky_q;
  assign err_count_o  = err_q;
  assign beat_count_o = beat_q;
  assign state_o      = state_q;

endmodule

// File: rtl/seq_checker.sv
// Multi-channel sequence checker: slices the buses into independent channel checkers.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned START      = 1,
  parameter bit          LOCK_FIRST = 1'b0,
  parameter bit          RESYNC     = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [CHANNELS-1:0]       failure,
  output logic [CHANNELS-1:0]       sticky_fail,
  output logic [CHANNELS*CNT_W-1:0] err_count,
  output logic [CHANNELS*CNT_W-1:0] beat_count,
  output logic                      any_fail,
  output logic [CHANNELS-1:0]       dbg_state
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    seq_checker_channel #(
      .WIDTH     (WIDTH),
      .START     (START),
      .LOCK_FIRST(LOCK_FIRST),
      .RESYNC    (RESYNC),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (clear),
      .en_i        (en[i]),
      .data_i      (data[i*WIDTH +: WIDTH]),
      .failure_o   (failure[i]),
      .sticky_o    (sticky_fail[i]),
      .err_count_o (err_count[i*CNT_W +: CNT_W]),
      .beat_count_o(beat_count[i*CNT_W +: CNT_W]),
      .state_o     (dbg_state[i +: 1])
    );
  end

  assign any_fail = |sticky_fail;

endmodule

// File: tb/tb_seq_checker.sv
// Directed scoreboard bench for seq_checker across four parameter sets.
module tb_seq_checker;

  // Instance 0: defaults, 1: RESYNC=1, 2: LOCK_FIRST=1, 3: START=14.
  logic       clk;
  logic       rst;
  logic       clear_s  [4];
  logic [1:0] en_s     [4];
  logic [7:0] data_s   [4];
  logic [1:0] fail_s   [4];
  logic [1:0] sticky_s [4];
  logic [1:0] st_s     [4];
  logic [15:0] err_s   [4];
  logic [15:0] beat_s  [4];
  logic       anyf_s   [4];

  typedef struct packed {
    logic [1:0]  inst;
    logic [1:0]  fail;
    logic [1:0]  sticky;
    logic [1:0]  st;
    logic [15:0] err;
    logic [15:0] beat;
    logic        anyf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;

  seq_checker u_a (
    .clk(clk), .rst(rst), .clear(clear_s[0]), .en(en_s[0]), .data(data_s[0]),
    .failure(fail_s[0]), .sticky_fail(sticky_s[0]), .err_count(err_s[0]),
    .beat_count(beat_s[0]), .any_fail(anyf_s[0]), .dbg_state(st_s[0])
  );
  seq_checker #(.RESYNC(1'b1)) u_r (
    .clk(clk), .rst(rst), .clear(clear_s[1]), .en(en_s[1]), .data(data_s[1]),
    .failure(fail_s[1]), .sticky_fail(sticky_s[1]), .err_count(err_s[1]),
    .beat_count(beat_s[1]), .any_fail(anyf_s[1]), .dbg_state(st_s[1])
  );
  seq_checker #(.LOCK_FIRST(1'b1)) u_l (
    .clk(clk), .rst(rst), .clear(clear_s[2]), .en(en_s[2]), .data(data_s[2]),
    .failure(fail_s[2]), .sticky_fail(sticky_s[2]), .err_count(err_s[2]),
    .beat_count(beat_s[2]), .any_fail(anyf_s[2]), .dbg_state(st_s[2])
  );
  seq_checker #(.START(14)) u_w (
    .clk(clk), .rst(rst), .clear(clear_s[3]), .en(en_s[3]), .data(data_s[3]),
    .failure(fail_s[3]), .sticky_fail(sticky_s[3]), .err_count(err_s[3]),
    .beat_count(beat_s[3]), .any_fail(anyf_s[3]), .dbg_state(st_s[3])
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input int i, input logic [1:0] est);
    chk($sformatf("i%0d_failure", i), 32'(fail_s[i]), 32'd0);
    chk($sformatf("i%0d_sticky", i), 32'(sticky_s[i]), 32'd0);
    chk($sformatf("i%0d_err", i), 32'(err_s[i]), 32'd0);
    chk($sformatf("i%0d_beat", i), 32'(beat_s[i]), 32'd0);
    chk($sformatf("i%0d_any_fail", i), 32'(anyf_s[i]), 32'd0);
    chk($sformatf("i%0d_state", i), 32'(st_s[i]), 32'(est));
  endtask

  // Driver: one cycle of stimulus on one instance plus the response expected after the edge.
  task automatic cyc(input int inst, input logic clr, input logic [1:0] en,
                     input logic [3:0] d1, input logic [3:0] d0, input exp_t e);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      clear_s[k] = 1'b0;
      en_s[k]    = 2'b00;
    end
    clear_s[inst] = clr;
    en_s[inst]    = en;
    data_s[inst]  = {d1, d0};
    exp_q.push_back(e);
  endtask

  // Channel-0-only beat; channel 1 is expected to stay at its reset values.
  task automatic b0(input int inst, input logic clr, input logic en0, input logic [3:0] d,
                    input logic ef, input logic es, input logic [7:0] ee,
                    input logic [7:0] eb, input logic est);
    exp_t e;
    e.inst   = 2'(inst);
    e.fail   = {1'b0, ef};
    e.sticky = {1'b0, es};
    e.st     = {(inst == 2) ? 1'b0 : 1'b1, est};
    e.err    = {8'd0, ee};
    e.beat   = {8'd0, eb};
    e.anyf   = es;
    cyc(inst, clr, {1'b0, en0}, 4'd0, d, e);
  endtask

  // Monitor: outputs for the beat sampled at this edge are compared just after it.
  exp_t m_e;
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk($sformatf("i%0d_failure", m_e.inst), 32'(fail_s[m_e.inst]), 32'(m_e.fail));
      chk($sformatf("i%0d_sticky", m_e.inst), 32'(sticky_s[m_e.inst]), 32'(m_e.sticky));
      chk($sformatf("i%0d_err", m_e.inst), 32'(err_s[m_e.inst]), 32'(m_e.err));
      chk($sformatf("i%0d_beat", m_e.inst), 32'(beat_s[m_e.inst]), 32'(m_e.beat));
      chk($sformatf("i%0d_any_fail", m_e.inst), 32'(anyf_s[m_e.inst]), 32'(m_e.anyf));
      chk($sformatf("i%0d_state", m_e.inst), 32'(st_s[m_e.inst]), 32'(m_e.st));
    end
  end

  initial begin
    exp_t e;
    logic [7:0] sat;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      clear_s[k] = 1'b0;
      en_s[k]    = 2'b00;
      data_s[k]  = 8'h00;
    end
    #3;
    for (int k = 0; k < 4; k++) chk_idle(k, (k == 2) ? 2'b00 : 2'b11);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean stream 1,2,3
    b0(0, 0, 1, 4'd1, 0, 0, 8'd0, 8'd1, 1);
    b0(0, 0, 1, 4'd2, 0, 0, 8'd0, 8'd2, 1);
    b0(0, 0, 1, 4'd3, 0, 0, 8'd0, 8'd3, 1);

    // RESYNC=0: 1,2,7,4 then an idle cycle
    b0(0, 1, 1, 4'd9, 0, 0, 8'd0, 8'd0, 1);
    b0(0, 0, 1, 4'd1, 0, 0, 8'd0, 8'd1, 1);
    b0(0, 0, 1, 4'd2, 0, 0, 8'd0, 8'd2, 1);
    b0(0, 0, 1, 4'd7, 1, 1, 8'd1, 8'd3, 1);
    b0(0, 0, 1, 4'd4, 0, 1, 8'd1, 8'd4, 1);
    b0(0, 0, 0, 4'd0, 0, 1, 8'd1, 8'd4, 1);

    // RESYNC=0: 1,2,7,8 -> the 8 fails too
    b0(0, 1, 0, 4'd0, 0, 0, 8'd0, 8'd0, 1);
    b0(0, 0, 1, 4'd1, 0, 0, 8'd0, 8'd1, 1);
    b0(0, 0, 1, 4'd2, 0, 0, 8'd0, 8'd2, 1);
    b0(0, 0, 1, 4'd7, 1, 1, 8'd1, 8'd3, 1);
    b0(0, 0, 1, 4'd8, 1, 1, 8'd2, 8'd4, 1);

    // RESYNC=1: 1,2,7,8,9 -> only the 7 fails
    b0(1, 0, 1, 4'd1, 0, 0, 8'd0, 8'd1, 1);
    b0(1, 0, 1, 4'd2, 0, 0, 8'd0, 8'd2, 1);
    b0(1, 0, 1, 4'd7, 1, 1, 8'd1, 8'd3, 1);
    b0(1, 0, 1, 4'd8, 0, 1, 8'd1, 8'd4, 1);
    b0(1, 0, 1, 4'd9, 0, 1, 8'd1, 8'd5, 1);

    // START=14 wrap: 14,15,0,1
    b0(3, 0, 1, 4'd14, 0, 0, 8'd0, 8'd1, 1);
    b0(3, 0, 1, 4'd15, 0, 0, 8'd0, 8'd2, 1);
    b0(3, 0, 1, 4'd0,  0, 0, 8'd0, 8'd3, 1);
    b0(3, 0, 1, 4'd1,  0, 0, 8'd0, 8'd4, 1);

    // LOCK_FIRST=1: 9,10,11; clear with en high; relock on 5; 6 ok; 9 fails
    b0(2, 0, 1, 4'd9,  0, 0, 8'd0, 8'd1, 1);
    b0(2, 0, 1, 4'd10, 0, 0, 8'd0, 8'd2, 1);
    b0(2, 0, 1, 4'd11, 0, 0, 8'd0, 8'd3, 1);
    b0(2, 1, 1, 4'd3,  0, 0, 8'd0, 8'd0, 0);
    b0(2, 0, 1, 4'd5,  0, 0, 8'd0, 8'd1, 1);
    b0(2, 0, 1, 4'd6,  0, 0, 8'd0, 8'd2, 1);
    b0(2, 0, 1, 4'd9,  1, 1, 8'd1, 8'd3, 1);

    // Two channels, ch1 always off by 8, run past counter saturation
    e = '{inst: 2'd0, fail: 2'b00, sticky: 2'b00, st: 2'b11, err: 16'd0, beat: 16'd0, anyf: 1'b0};
    cyc(0, 1'b1, 2'b11, 4'd5, 4'd5, e);
    for (int k = 0; k < 300; k++) begin
      sat = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
      e = '{inst: 2'd0, fail: 2'b10, sticky: 2'b10, st: 2'b11,
            err: {sat, 8'd0}, beat: {sat, sat}, anyf: 1'b1};
      cyc(0, 1'b0, 2'b11, 4'((k + 9) % 16), 4'((k + 1) % 16), e);
    end

    // Asynchronous reset mid-stream
    @(negedge clk);
    en_s[0]   = 2'b11;
    data_s[0] = 8'h33;
    #2 rst = 1'b1;
    #1 chk_idle(0, 2'b11);
    @(negedge clk);
    rst     = 1'b0;
    en_s[0] = 2'b00;
    chk_idle(0, 2'b11);
    b0(0, 0, 1, 4'd1, 0, 0, 8'd0, 8'd1, 1);
    b0(0, 0, 0, 4'd0, 0, 0, 8'd0, 8'd1, 1);

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
